viterbi_output_packer: RTL and testbench
========================================

Name: viterbi_output_packer

Overview:
Parametrised successor to the fixed 1-to-8 serial-in/parallel-out stage that follows the Viterbi decoder. Collects SIZE_IN-bit decoded chunks into SIZE_OUT-bit words with selectable bit order. Closes partial words at end of frame with padding and a bit count. Buffers completed words in a FIFO with valid/ready backpressure and sticky overflow reporting, because the decoder cannot be stalled.

Parameters:
SIZE_IN, 1, width of each input chunk from the decoder; SIZE_OUT must be an integer multiple of SIZE_IN
SIZE_OUT, 8, width of each packed output word
FIFO_DEPTH, 4, number of output word entries; power of 2, at least 2
PAD_BIT, 0, value written into unfilled bit positions of a partial word

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input chunk valid; always accepted, no backpressure
i_data  in  SIZE_IN  decoded chunk
i_last  in  1  qualified by i_valid; marks the final chunk of a frame
i_msb_first  in  1  bit order; 1 = first chunk lands in o_data MSBs
i_ready  in  1  downstream ready
i_clr_ovf  in  1  clears o_overflow
o_data  out  SIZE_OUT  packed word at FIFO head
o_valid  out  1  FIFO non-empty
o_last  out  1  head word is the last word of a frame
o_nbits  out  clog2(SIZE_OUT)+1  valid bits in the head word; SIZE_OUT for full words
o_overflow  out  1  sticky; a completed word was dropped
o_done  out  1  one-cycle pulse when a word with o_last=1 is popped

Behaviour:
- Reset (asynchronous): all outputs 0; FIFO empty; beat counter 0; state IDLE.
- Derived constant: BEATS = SIZE_OUT/SIZE_IN chunks per word.
- State machine, 2 states:
  - IDLE: no chunks pending. On i_valid, latch i_msb_first for the word, store the chunk, and go to FILL. If the chunk also completes the word (BEATS=1 or i_last), push it and stay in IDLE.
  - FILL: each i_valid stores a chunk and increments the beat counter. A word completes when the counter reaches BEATS or i_last=1. On completion, push the word and return to IDLE.
- Bit order:
  - MSB-first: chunk k occupies o_data[SIZE_OUT-1-k*SIZE_IN -: SIZE_IN].
  - LSB-first: chunk k occupies o_data[k*SIZE_IN +: SIZE_IN].
  - i_msb_first is sampled only on the first chunk of each word; changing it mid-word has no effect.
- Partial word on i_last: unfilled positions take PAD_BIT. o_nbits = SIZE_IN × chunks received. o_last=1.
- A full word that also carries i_last: o_last=1, o_nbits=SIZE_OUT.
- Latency: the chunk that completes a word is sampled at edge t; the word is visible at the FIFO head with o_valid=1 after edge t if the FIFO was empty. No combinational path from input to output.
- Pop occurs on o_valid & i_ready at a rising edge; o_data, o_last and o_nbits are stable while o_valid=1 and i_ready=0.
- Push when full:
  - With a pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Without a pop: the word is dropped, o_overflow goes to 1 the next cycle, and packing continues normally.
- i_clr_ovf clears o_overflow on the next edge. A drop in the same cycle takes priority and leaves o_overflow=1.
- Pop from empty is impossible, since i_ready is ignored when o_valid=0.
- FIFO pointers carry an extra wrap bit: full = equal indices with differing wrap bits; empty = pointers equal.
- o_done is registered; it is high for the cycle after the edge that pops a head word with o_last=1.
- Reset mid-frame discards pending chunks and FIFO contents immediately.

Test Plan:
- SIZE_IN=1, SIZE_OUT=8, i_msb_first=1, i_ready=1, bits 1,0,1,1,0,0,1,0 -> o_data=8'hB2, o_valid high for 1 cycle, starting the cycle after the 8th chunk, o_nbits=8, o_last=0.
- Same bits with i_msb_first=0 -> o_data=8'h4D.
- MSB-first, chunks 1,1,0 with i_last on the 3rd, PAD_BIT=0 -> o_data=8'hC0, o_nbits=3, o_last=1, o_done pulses after the pop. Then 2 more chunks start a fresh word correctly.
- FIFO_DEPTH=4, i_ready=0, 5 full words -> o_overflow=1 after the 5th word; raising i_ready drains exactly the first 4 words in order; i_clr_ovf clears the flag.
- FIFO full and i_ready=1 in the cycle a 5th word completes -> no drop, o_overflow stays 0, all 5 words delivered.
- SIZE_IN=2, SIZE_OUT=16, MSB-first: feed 3 chunks, assert i_rst mid-word, then 8 chunks of 2'b11 -> only 16'hFFFF emerges, with no stale bits.

Source files
------------

// File: rtl/viterbi_output_packer.sv
// viterbi_output_packer: packs SIZE_IN-bit decoded chunks into SIZE_OUT-bit
// words (selectable bit order, padded partial words at end of frame) and
// queues them in a FIFO with valid/ready output and sticky overflow flag.
module viterbi_output_packer #(
  parameter int unsigned SIZE_IN    = 1,
  parameter int unsigned SIZE_OUT   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PAD_BIT    = 1'b0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [SIZE_IN-1:0]          i_data,
  input  logic                        i_last,
  input  logic                        i_msb_first,
  input  logic                        i_ready,
  input  logic                        i_clr_ovf,
  output logic [SIZE_OUT-1:0]         o_data,
  output logic                        o_valid,
  output logic                        o_last,
  output logic [$clog2(SIZE_OUT):0]   o_nbits,
  output logic                        o_overflow,
  output logic                        o_done
);

  localparam int unsigned BEATS = SIZE_OUT / SIZE_IN;
  localparam int unsigned CW    = $clog2(BEATS + 1);
  localparam int unsigned NW    = $clog2(SIZE_OUT) + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              r_state;
  logic [SIZE_OUT-1:0] r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_msb;

  logic [SIZE_OUT-1:0] w_word;
  logic [NW-1:0]       w_nbits;
  logic [CW-1:0]       w_k;
  logic [CW-1:0]       w_k1;
  logic                w_msb;
  logic                w_push;

  logic [SIZE_OUT-1:0] r_mem_data  [FIFO_DEPTH];
  logic                r_mem_last  [FIFO_DEPTH];
  logic [NW-1:0]       r_mem_nbits [FIFO_DEPTH];
  logic [AW:0]         r_wr;
  logic [AW:0]         r_rd;
  logic                r_ovf;
  logic                r_done;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_wr_en;
  logic                w_drop;

  // Merge the incoming chunk into the word under construction; a word that
  // starts in IDLE begins from an all-PAD_BIT image so partial words are padded.
  always_comb begin
    w_k     = (r_state == S_FILL) ? r_cnt : '0;
    w_k1    = w_k + CW'(1);
    w_msb   = (r_state == S_FILL) ? r_msb : i_msb_first;
    w_word  = (r_state == S_FILL) ? r_acc : {SIZE_OUT{PAD_BIT}};
    w_nbits = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (w_k == CW'(b)) begin
        if (w_msb) w_word[SIZE_OUT-1-b*SIZE_IN -: SIZE_IN] = i_data;
        else       w_word[b*SIZE_IN +: SIZE_IN]            = i_data;
        w_nbits = NW'((b + 1) * SIZE_IN);
      end
    end
    w_push = i_valid && (i_last || (w_k1 == CW'(BEATS)));
  end

  // Packing FSM: IDLE waits for the first chunk of a word, FILL collects the rest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_acc   <= {SIZE_OUT{PAD_BIT}};
      r_cnt   <= '0;
      r_msb   <= 1'b0;
    end else if (i_valid) begin
      if (w_push) begin
        r_state <= S_IDLE;
        r_acc   <= {SIZE_OUT{PAD_BIT}};
        r_cnt   <= '0;
      end else begin
        r_state <= S_FILL;
        r_acc   <= w_word;
        r_cnt   <= w_k1;
        r_msb   <= w_msb;
      end
    end
  end

  // FIFO status; a push into a full FIFO survives only if the head pops alongside.
  always_comb begin
    w_empty = (r_wr == r_rd);
    w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    w_pop   = !w_empty && i_ready;
    w_wr_en = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
  end

  // FIFO storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_last[i]  <= 1'b0;
        r_mem_nbits[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem_data[r_wr[AW-1:0]]  <= w_word;
      r_mem_last[r_wr[AW-1:0]]  <= i_last;
      r_mem_nbits[r_wr[AW-1:0]] <= w_nbits;
    end
  end

  // Pointers, sticky overflow (drop beats clear) and end-of-frame pop pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
      r_done <= w_pop && r_mem_last[r_rd[AW-1:0]];
    end
  end

  assign o_data     = r_mem_data[r_rd[AW-1:0]];
  assign o_last     = r_mem_last[r_rd[AW-1:0]];
  assign o_nbits    = r_mem_nbits[r_rd[AW-1:0]];
  assign o_valid    = !w_empty;
  assign o_overflow = r_ovf;
  assign o_done     = r_done;

endmodule

// File: tb/tb_viterbi_output_packer.sv
// Bench for viterbi_output_packer: a 1->8 instance and a 2->16 instance,
// expected words queued when stimulus is driven and compared on each pop.
module tb_viterbi_output_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: SIZE_IN=1, SIZE_OUT=8
  logic       rst0, v0, last0, msb0, rdy0, clr0;
  logic [0:0] d0;
  logic [7:0] od0;
  logic       ov0, ol0, oovf0, odone0;
  logic [3:0] onb0;

  // instance 1: SIZE_IN=2, SIZE_OUT=16
  logic        rst1, v1, last1, msb1, rdy1, clr1;
  logic [1:0]  d1;
  logic [15:0] od1;
  logic        ov1, ol1, oovf1, odone1;
  logic [4:0]  onb1;

  viterbi_output_packer #(.SIZE_IN(1), .SIZE_OUT(8), .FIFO_DEPTH(4), .PAD_BIT(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_valid(v0), .i_data(d0), .i_last(last0),
    .i_msb_first(msb0), .i_ready(rdy0), .i_clr_ovf(clr0),
    .o_data(od0), .o_valid(ov0), .o_last(ol0), .o_nbits(onb0),
    .o_overflow(oovf0), .o_done(odone0));

  viterbi_output_packer #(.SIZE_IN(2), .SIZE_OUT(16), .FIFO_DEPTH(4), .PAD_BIT(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_valid(v1), .i_data(d1), .i_last(last1),
    .i_msb_first(msb1), .i_ready(rdy1), .i_clr_ovf(clr1),
    .o_data(od1), .o_valid(ov1), .o_last(ol1), .o_nbits(onb1),
    .o_overflow(oovf1), .o_done(odone1));

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [4:0]  nbits;
  } exp_t;

  // chunk k of a word is bits[7-k]; chunks after the first use the opposite msb
  typedef struct {
    logic [7:0] bits;
    int         n;
    logic       msb;
    logic       last;
    logic [7:0] exp;
    logic [3:0] nb;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic ed0 = 1'b0;
  logic ed1 = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard for instance 0: compare head word when it pops, track o_done
  always @(negedge clk) begin
    if (rst0) ed0 = 1'b0;
    else begin
      chk("done0", {31'b0, odone0}, {31'b0, ed0});
      ed0 = 1'b0;
      if (ov0 && rdy0) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop0_extra: got word %0h expected none", od0);
        end else begin
          e0 = q0.pop_front();
          chk("data0",  {24'b0, od0},  {24'b0, e0.data[7:0]});
          chk("last0",  {31'b0, ol0},  {31'b0, e0.last});
          chk("nbits0", {28'b0, onb0}, {28'b0, e0.nbits[3:0]});
          ed0 = e0.last;
        end
      end
    end
  end

  // scoreboard for instance 1
  always @(negedge clk) begin
    if (rst1) ed1 = 1'b0;
    else begin
      chk("done1", {31'b0, odone1}, {31'b0, ed1});
      ed1 = 1'b0;
      if (ov1 && rdy1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop1_extra: got word %0h expected none", od1);
        end else begin
          e1 = q1.pop_front();
          chk("data1",  {16'b0, od1},  {16'b0, e1.data});
          chk("last1",  {31'b0, ol1},  {31'b0, e1.last});
          chk("nbits1", {27'b0, onb1}, {27'b0, e1.nbits});
          ed1 = e1.last;
        end
      end
    end
  end

  task automatic chunk0(input logic b, input logic l, input logic m);
    v0 = 1'b1; d0 = b; last0 = l; msb0 = m;
    @(posedge clk); #1;
    v0 = 1'b0; last0 = 1'b0;
  endtask

  task automatic chunk1(input logic [1:0] b, input logic l, input logic m);
    v1 = 1'b1; d1 = b; last1 = l; msb1 = m;
    @(posedge clk); #1;
    v1 = 1'b0; last1 = 1'b0;
  endtask

  // full 8-chunk MSB-first word on instance 0; optionally raise ready with the last chunk
  task automatic word0(input logic [7:0] bits, input logic rdy_on_last);
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && rdy_on_last) rdy0 = 1'b1;
      chunk0(bits[7-k], 1'b0, 1'b1);
    end
  endtask

  vec_t vt[8];
  logic [7:0] wb;

  initial begin
    vt[0] = '{8'hB2, 8, 1'b1, 1'b0, 8'hB2, 4'd8};
    vt[1] = '{8'hB2, 8, 1'b0, 1'b0, 8'h4D, 4'd8};
    vt[2] = '{8'hC0, 3, 1'b1, 1'b1, 8'hC0, 4'd3};
    vt[3] = '{8'hA0, 3, 1'b0, 1'b1, 8'h05, 4'd3};
    vt[4] = '{8'hF0, 8, 1'b1, 1'b1, 8'hF0, 4'd8};
    vt[5] = '{8'h80, 1, 1'b1, 1'b1, 8'h80, 4'd1};
    vt[6] = '{8'h80, 1, 1'b0, 1'b1, 8'h01, 4'd1};
    vt[7] = '{8'h69, 8, 1'b1, 1'b0, 8'h69, 4'd8};

    rst0 = 1'b1; v0 = 1'b0; d0 = '0; last0 = 1'b0; msb0 = 1'b0; rdy0 = 1'b1; clr0 = 1'b0;
    rst1 = 1'b1; v1 = 1'b0; d1 = '0; last1 = 1'b0; msb1 = 1'b0; rdy1 = 1'b1; clr1 = 1'b0;
    #2;
    chk("rst_data",  {24'b0, od0},  32'h0);
    chk("rst_valid", {31'b0, ov0},  32'h0);
    chk("rst_last",  {31'b0, ol0},  32'h0);
    chk("rst_nbits", {28'b0, onb0}, 32'h0);
    chk("rst_ovf",   {31'b0, oovf0}, 32'h0);
    chk("rst_done",  {31'b0, odone0}, 32'h0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // table: one word per entry, visible right after its completing edge, gone a cycle later
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{{8'h00, vt[i].exp}, vt[i].last, {1'b0, vt[i].nb}});
      wb = vt[i].bits;
      for (int k = 0; k < vt[i].n; k++)
        chunk0(wb[7-k], (k == vt[i].n - 1) && vt[i].last, (k == 0) ? vt[i].msb : !vt[i].msb);
      chk("latency_valid", {31'b0, ov0}, 32'h1);
      @(posedge clk); #1;
      chk("single_cycle_valid", {31'b0, ov0}, 32'h0);
    end

    // overflow: five words into a stalled 4-deep FIFO, the fifth is dropped
    rdy0 = 1'b0;
    for (int w = 0; w < 5; w++) begin
      wb = 8'(8'h11 * (w + 1));
      if (w < 4) q0.push_back('{{8'h00, wb}, 1'b0, 5'd8});
      word0(wb, 1'b0);
      if (w == 3) chk("ovf_before_drop", {31'b0, oovf0}, 32'h0);
    end
    chk("ovf_after_drop", {31'b0, oovf0}, 32'h1);
    chk("full_valid", {31'b0, ov0}, 32'h1);
    @(posedge clk); #1;
    chk("ovf_sticky", {31'b0, oovf0}, 32'h1);
    rdy0 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain4_q", q0.size(), 32'h0);
    chk("drain4_empty", {31'b0, ov0}, 32'h0);
    chk("ovf_held", {31'b0, oovf0}, 32'h1);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("ovf_cleared", {31'b0, oovf0}, 32'h0);

    // full FIFO with a pop in the completing cycle: nothing is dropped
    rdy0 = 1'b0;
    for (int w = 0; w < 5; w++) begin
      wb = 8'(8'hA1 + w);
      q0.push_back('{{8'h00, wb}, 1'b0, 5'd8});
      word0(wb, w == 4);
    end
    chk("no_drop_ovf", {31'b0, oovf0}, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    chk("drain5_q", q0.size(), 32'h0);
    chk("no_drop_ovf_end", {31'b0, oovf0}, 32'h0);

    // instance 1: reset in the middle of a word discards the pending chunks
    for (int k = 0; k < 3; k++) chunk1(2'b01, 1'b0, 1'b1);
    rst1 = 1'b1;
    #3;
    chk("async_rst_valid", {31'b0, ov1}, 32'h0);
    chk("async_rst_data", {16'b0, od1}, 32'h0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    q1.push_back('{16'hFFFF, 1'b0, 5'd16});
    for (int k = 0; k < 8; k++) chunk1(2'b11, 1'b0, 1'b1);
    chk("w16_latency", {31'b0, ov1}, 32'h1);
    @(posedge clk); #1;
    q1.push_back('{16'h0006, 1'b1, 5'd4});
    chunk1(2'b10, 1'b0, 1'b0);
    chunk1(2'b01, 1'b1, 1'b1);
    q1.push_back('{16'h9000, 1'b1, 5'd4});
    chunk1(2'b10, 1'b0, 1'b1);
    chunk1(2'b01, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("q1_empty", q1.size(), 32'h0);
    chk("q0_empty", q0.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
